// File: rtl/seq_shift_add_mult_if.sv
// Purpose: bundles the start/operand/result signals of the shift-and-add multiplier.
// Ports: start, a, b (requester to multiplier); busy, done, product (multiplier to requester).
// master = ALU control side that issues requests, slave = the multiplier itself.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Purpose: unsigned multi-cycle shift-and-add multiplier, one partial product per clock.
// Latency: start sampled at E0, product/done update at E(WIDTH), done clears at E(WIDTH+1).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low); bus (slave): start, a, b in; busy, done, product out.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_shift_add_mult_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] product, product_nxt;
  logic               done, done_nxt;
  logic [2*WIDTH-1:0] acc_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      product <= product_nxt;
      done    <= done_nxt;
    end
  end

  // Accumulator including this cycle's partial product; also feeds product
  // on the last RUN cycle so the final add is not lost.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    product_nxt = product;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt  = {{WIDTH{1'b0}}, bus.a};
          mplier_nxt = bus.b;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == LAST) begin
          product_nxt = acc_sum;
          done_nxt    = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.product = product;

endmodule
